load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDRESS_SIZE, default 10: word-address width of the attached block memory.
REQ-002 Port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port rst_n  input  1  reset; asynchronous assertion, active low.
REQ-004 Port req_valid  input  1  CPU request present.
REQ-005 Port req_ready  output  1  unit accepts a request this cycle.
REQ-006 Port req_write  input  1  1 = store, 0 = load.
REQ-007 Port req_funct3  input  3  RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-008 Port req_address  input  ADDRESS_SIZE+2  byte address.
REQ-009 Port req_wdata  input  32  store data, right-aligned.
REQ-010 Port resp_valid  output  1  one-cycle completion pulse.
REQ-011 Port resp_rdata  output  32  formatted load result.
REQ-012 Port resp_error  output  1  request rejected (misaligned or illegal width).
REQ-013 Port mem_read_enable  output  1  memory read strobe.
REQ-014 Port mem_write_enable  output  1  memory write strobe.
REQ-015 Port mem_read_address  output  ADDRESS_SIZE  word address for reads.
REQ-016 Port mem_write_address  output  ADDRESS_SIZE  word address for writes.
REQ-017 Port mem_write_data  output  32  full word to write.
REQ-018 Port mem_read_data  input  32  memory data, valid the cycle after a read strobe, held until the next strobe.

Function
REQ-019 The unit SHALL implement states IDLE, READ, LOAD_DATA, WRITE; req_ready SHALL equal (state == IDLE).
REQ-020 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_write, req_funct3, req_address and req_wdata are latched at that edge.
REQ-021 Illegal request: load funct3 in {3,6,7}; store funct3 > 2; H/HU with address[0]=1; W with address[1:0]!=0.
REQ-022 Illegal request: state stays IDLE; next cycle resp_valid=1, resp_error=1, resp_rdata=0; no memory strobe issued.
REQ-023 Legal load: IDLE->READ->LOAD_DATA->IDLE; resp_valid in the cycle after LOAD_DATA (accept edge T, response cycle T+3).
REQ-024 Legal SB/SH: IDLE->READ->WRITE->IDLE; response cycle T+3.
REQ-025 Legal SW: IDLE->WRITE->IDLE; response cycle T+2.
REQ-026 mem_read_enable SHALL be 1 only in READ; mem_write_enable SHALL be 1 only in WRITE; both decode combinationally from state.
REQ-027 mem_read_address and mem_write_address SHALL equal latched address[ADDRESS_SIZE+1:2].
REQ-028 LOAD_DATA SHALL register resp_rdata from mem_read_data, byte lane = address[1:0] (halfword lane = address[1]).
REQ-029 Load formatting: B/H sign-extend; BU/HU zero-extend; W unchanged.
REQ-030 WRITE data: SW = latched wdata; SB/SH = mem_read_data with lane replaced by wdata[7:0]/wdata[15:0], other lanes unchanged.
REQ-031 Store response: resp_rdata=0, resp_error=0; legal load response: resp_error=0.
REQ-032 resp_valid and resp_error SHALL be registered one-cycle pulses; resp_rdata holds its value until the next response.
REQ-033 A new request SHALL be acceptable in the same cycle resp_valid is high (back-to-back).
REQ-034 A write completes before any later read, so a load following a store to the same word returns the stored data.

Reset
REQ-035 While rst_n=0: state=IDLE, resp_valid=0, resp_error=0, resp_rdata=0, strobes 0, latched request cleared.
REQ-036 Reset mid-operation SHALL abort immediately: strobes drop asynchronously; no response issued; req_ready=1 on the first edge after release.

Verification
REQ-037 Word 5 = 0x884422F1; LB at 0x14 -> 0xFFFFFFF1 and LBU at 0x15 -> 0x00000022, each with resp_valid at T+3 and one read strobe.
REQ-038 Same word: LH at 0x16 -> 0xFFFF8844; LHU at 0x16 -> 0x00008844.
REQ-039 SB at 0x17 with wdata 0x000000AB -> one read, then one write of 0xAB4422F1 to word 5, resp_valid at T+3.
REQ-040 LW at 0x16, and funct3=3 load -> resp_valid=resp_error=1 at T+1; no strobe ever asserted.
REQ-041 SW 0xDEADBEEF at 0x20, then LW at 0x20 issued in the response cycle -> 0xDEADBEEF at T+3 of the load.
REQ-042 rst_n pulsed low during READ -> strobes 0 at once, no resp_valid; next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store front end for a single-port-style block memory.
// Sub-word stores read the word first, then write back the merged word.
module load_store_unit #(
  parameter int ADDRESS_SIZE = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [2:0]              req_funct3,
  input  logic [ADDRESS_SIZE+1:0] req_address,
  input  logic [31:0]             req_wdata,
  output logic                    resp_valid,
  output logic [31:0]             resp_rdata,
  output logic                    resp_error,
  output logic                    mem_read_enable,
  output logic                    mem_write_enable,
  output logic [ADDRESS_SIZE-1:0] mem_read_address,
  output logic [ADDRESS_SIZE-1:0] mem_write_address,
  output logic [31:0]             mem_write_data,
  input  logic [31:0]             mem_read_data
);
  typedef enum logic [1:0] {IDLE, READ, LOAD_DATA, WRITE} state_t;
  state_t                  state_q;
  logic                    write_q;
  logic [2:0]              funct3_q;
  logic [ADDRESS_SIZE+1:0] addr_q;
  logic [31:0]             wdata_q;
  logic                    resp_valid_q;
  logic                    resp_error_q;
  logic [31:0]             resp_rdata_q;
  logic                    illegal;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;
  logic [31:0]             load_data;
  logic [4:0]              sh;
  logic [31:0]             mask;
  always_comb begin
    illegal = req_write
      ? (req_funct3 > 3'd2 || (req_funct3 == 3'd1 && req_address[0]) ||
         (req_funct3 == 3'd2 && req_address[1:0] != 2'd0))
      : (req_funct3 == 3'd3 || req_funct3 > 3'd5 ||
         ((req_funct3 == 3'd1 || req_funct3 == 3'd5) && req_address[0]) ||
         (req_funct3 == 3'd2 && req_address[1:0] != 2'd0));
    rd_byte   = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    rd_half   = mem_read_data[{addr_q[1], 4'b0000} +: 16];
    load_data = funct3_q == 3'd0 ? {{24{rd_byte[7]}}, rd_byte} :
                funct3_q == 3'd1 ? {{16{rd_half[15]}}, rd_half} :
                funct3_q == 3'd4 ? {24'd0, rd_byte} :
                funct3_q == 3'd5 ? {16'd0, rd_half} : mem_read_data;
    // Merge the store lane into the word fetched during READ.
    sh             = funct3_q[0] ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
    mask           = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    mem_write_data = funct3_q[1] ? wdata_q : (mem_read_data & ~mask) | ((wdata_q << sh) & mask);
  end
  assign req_ready         = state_q == IDLE;
  assign mem_read_enable   = state_q == READ;
  assign mem_write_enable  = state_q == WRITE;
  assign mem_read_address  = addr_q[ADDRESS_SIZE+1:2];
  assign mem_write_address = addr_q[ADDRESS_SIZE+1:2];
  assign resp_valid        = resp_valid_q;
  assign resp_error        = resp_error_q;
  assign resp_rdata        = resp_rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          write_q  <= req_write;
          funct3_q <= req_funct3;
          addr_q   <= req_address;
          wdata_q  <= req_wdata;
          if (illegal) begin
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
            resp_rdata_q <= 32'd0;
          end else begin
            state_q <= (req_write && req_funct3 == 3'd2) ? WRITE : READ;
          end
        end
        READ: state_q <= write_q ? WRITE : LOAD_DATA;
        LOAD_DATA: begin
          resp_rdata_q <= load_data;
          resp_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        WRITE: begin
          resp_rdata_q <= 32'd0;
          resp_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a behavioural block memory.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [11:0] req_address = 12'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [9:0]  mem_read_address;
  logic [9:0]  mem_write_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = 32'd0;
  logic [31:0] mem [1024];
  int          n_checks = 0;
  int          n_errors = 0;
  int          lat, nr, nw, seen;
  logic [31:0] rd, wdat;
  logic        er;
  logic [9:0]  wadr;
  load_store_unit #(.ADDRESS_SIZE(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_address(req_address), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_read_enable) mem_read_data <= mem[mem_read_address];
    if (mem_write_enable) mem[mem_write_address] <= mem_write_data;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  // Called #1 after a rising edge; returns after the response cycle or an 8-cycle budget.
  task automatic run(input logic w, input logic [2:0] f, input logic [11:0] a, input logic [31:0] d);
    check("ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f; req_address = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; nr = 0; nw = 0; rd = 32'd0; er = 1'b0; wdat = 32'd0; wadr = 10'd0;
    for (int k = 1; k <= 8; k++) begin
      nr += int'(mem_read_enable);
      nw += int'(mem_write_enable);
      if (mem_write_enable) begin wdat = mem_write_data; wadr = mem_write_address; end
      if (resp_valid) begin lat = k; rd = resp_rdata; er = resp_error; break; end
      @(posedge clk); #1;
    end
  endtask
  task automatic tx(input string tag, input logic w, input logic [2:0] f, input logic [11:0] a,
                    input logic [31:0] d, input int elat, input logic [31:0] erd, input logic eer,
                    input int enr, input int enw);
    run(w, f, a, d);
    check({tag, ".lat"}, lat, elat);
    check({tag, ".rdata"}, rd, erd);
    check({tag, ".err"}, {31'd0, er}, {31'd0, eer});
    check({tag, ".reads"}, nr, enr);
    check({tag, ".writes"}, nw, enw);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[5] = 32'h884422F1;
    #12;
    check("rst.ready", {31'd0, req_ready}, 32'd1);
    check("rst.valid", {31'd0, resp_valid}, 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.strobes", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tx("lb14",  1'b0, 3'd0, 12'h014, 32'd0, 3, 32'hFFFFFFF1, 1'b0, 1, 0);
    tx("lbu15", 1'b0, 3'd4, 12'h015, 32'd0, 3, 32'h00000022, 1'b0, 1, 0);
    @(posedge clk); #1;
    check("hold.rdata", resp_rdata, 32'h00000022);
    check("hold.valid", {31'd0, resp_valid}, 32'd0);
    tx("lh16",  1'b0, 3'd1, 12'h016, 32'd0, 3, 32'hFFFF8844, 1'b0, 1, 0);
    tx("lhu16", 1'b0, 3'd5, 12'h016, 32'd0, 3, 32'h00008844, 1'b0, 1, 0);
    tx("lhu14", 1'b0, 3'd5, 12'h014, 32'd0, 3, 32'h000022F1, 1'b0, 1, 0);
    tx("sb17",  1'b1, 3'd0, 12'h017, 32'h000000AB, 3, 32'd0, 1'b0, 1, 1);
    check("sb17.wdata", wdat, 32'hAB4422F1);
    check("sb17.waddr", {22'd0, wadr}, 32'd5);
    tx("lw14",  1'b0, 3'd2, 12'h014, 32'd0, 3, 32'hAB4422F1, 1'b0, 1, 0);
    tx("lb17",  1'b0, 3'd0, 12'h017, 32'd0, 3, 32'hFFFFFFAB, 1'b0, 1, 0);
    tx("lw16",  1'b0, 3'd2, 12'h016, 32'd0, 1, 32'd0, 1'b1, 0, 0);
    tx("ld_f3", 1'b0, 3'd3, 12'h014, 32'd0, 1, 32'd0, 1'b1, 0, 0);
    tx("ld_f6", 1'b0, 3'd6, 12'h014, 32'd0, 1, 32'd0, 1'b1, 0, 0);
    tx("lh15",  1'b0, 3'd1, 12'h015, 32'd0, 1, 32'd0, 1'b1, 0, 0);
    tx("sh15",  1'b1, 3'd1, 12'h015, 32'h1234, 1, 32'd0, 1'b1, 0, 0);
    tx("st_f4", 1'b1, 3'd4, 12'h014, 32'h55, 1, 32'd0, 1'b1, 0, 0);
    tx("sw20",  1'b1, 3'd2, 12'h020, 32'hDEADBEEF, 2, 32'd0, 1'b0, 0, 1);
    check("sw20.wdata", wdat, 32'hDEADBEEF);
    check("sw20.waddr", {22'd0, wadr}, 32'd8);
    tx("lw20",  1'b0, 3'd2, 12'h020, 32'd0, 3, 32'hDEADBEEF, 1'b0, 1, 0);
    run(1'b0, 3'd2, 12'h020, 32'd0);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_address = 12'h014;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort.re_before", {31'd0, mem_read_enable}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort.re_now", {31'd0, mem_read_enable}, 32'd0);
    check("abort.valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 0) check("abort.ready", {31'd0, req_ready}, 32'd1);
      seen += int'(resp_valid);
    end
    check("abort.no_resp", seen, 0);
    tx("lw20b", 1'b0, 3'd2, 12'h020, 32'd0, 3, 32'hDEADBEEF, 1'b0, 1, 0);
    tx("sh22",  1'b1, 3'd1, 12'h022, 32'h1234CAFE, 3, 32'd0, 1'b0, 1, 1);
    check("sh22.wdata", wdat, 32'hCAFEBEEF);
    tx("lw20c", 1'b0, 3'd2, 12'h020, 32'd0, 3, 32'hCAFEBEEF, 1'b0, 1, 0);
    tx("lh20",  1'b0, 3'd1, 12'h020, 32'd0, 3, 32'hFFFFBEEF, 1'b0, 1, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
